conv_sequencer: RTL and testbench

- Top-level control FSM for the convolution datapath (N PEs, main buffer, window buffer, filter buffers, x/y/z address PCs).
- Sequences the full job from one start pulse:
  - load all N filters from memory;
  - fill the 4-row main buffer;
  - sweep 13 window positions per row, with a 16-cycle MAC per window;
  - shift in the next image row, repeated ROWS times;
  - finalize and pulse done.

---
 rtl/conv_sequencer.sv | 269 ++++++++++++++++++++++++++
 tb/tb_conv_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sequencer.sv
`timescale 1ns/1ps
// conv_sequencer
// Top-level control FSM for the convolution datapath (PEs, main buffer,
// window buffer, filter buffers, x/y/z address PCs). One start pulse runs a
// whole job: load all N filters, fill the 4-row main buffer, sweep 13 window
// positions per row with a 16-cycle MAC each, shift in a new image row
// (ROWS-1 times) and finish with a one-cycle done pulse.
//
// Ports
//   clk                              rising-edge clock
//   rst                              asynchronous active-low reset
//   start                            job request, sampled only in IDLE
//   write_filter_buff_counter_cout   2-bit filter write counter at 3
//   write_main_buff_counter_cout     2-bit main buffer write counter at 3
//   read_filter_buff_counter_cout    4-bit MAC index at 15
//   read_main_buff_counter_cout      window column counter at 12
//   sel_x/sel_y/sel_z                PC loads its init value
//   load_x/load_y/load_z             PC increment
//   mem_addr_sel                     1 = y (filter) address, 0 = x (image)
//   write_filter_buff_en[N]          one-hot PE filter write
//   write_filter_buff_counter_en     filter write counter enable
//   write_main_buff_en               main buffer write
//   write_main_buff_counter_en       main buffer write counter enable
//   shift_main_buff_en               main buffer row shift
//   read_main_buff_counter_en        window column counter enable
//   read_filter_buff_counter_en      MAC index counter enable
//   write_window_buff_en             window buffer capture
//   partial_res_en                   MAC accumulate enable
//   reset_mac                        clear MAC accumulator
//   shift_reg_en                     push MAC result into output shift reg
//   finalize_shift_reg               flush output shift register
//   done                             one-cycle completion pulse
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | waiting for start, all outputs low
// INIT         | load x/y/z PCs with their init values
// FILT         | 4*N filter word reads (y address)
// FILT_DRAIN   | last filter word lands in its buffer
// MAIN         | 4 image word reads filling the main buffer (x address)
// MAIN_DRAIN   | last main word lands; leave once the write counter wraps
// WIN          | capture window, clear MAC
// MAC          | 16 multiply-accumulate cycles
// ACC          | store result, advance z and window column
// SHIFT        | shift main buffer, step write counter 0 -> 3
// FETCH        | read one new image word
// FETCH_DRAIN  | new word lands in the main buffer
// FINAL        | flush output shift register
// DONE         | done pulse

module conv_sequencer #(
    parameter int N    = 1,
    parameter int ROWS = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         write_filter_buff_counter_cout,
    input  logic         write_main_buff_counter_cout,
    input  logic         read_filter_buff_counter_cout,
    input  logic         read_main_buff_counter_cout,
    output logic         sel_x,
    output logic         sel_y,
    output logic         sel_z,
    output logic         load_x,
    output logic         load_y,
    output logic         load_z,
    output logic         mem_addr_sel,
    output logic [N-1:0] write_filter_buff_en,
    output logic         write_filter_buff_counter_en,
    output logic         write_main_buff_en,
    output logic         write_main_buff_counter_en,
    output logic         shift_main_buff_en,
    output logic         read_main_buff_counter_en,
    output logic         read_filter_buff_counter_en,
    output logic         write_window_buff_en,
    output logic         partial_res_en,
    output logic         reset_mac,
    output logic         shift_reg_en,
    output logic         finalize_shift_reg,
    output logic         done
);

    localparam int FILT_ISSUES = 4 * N;
    localparam int IW          = $clog2(FILT_ISSUES + 1);
    localparam int FW          = $clog2(N + 1);
    localparam int RW          = $clog2(ROWS + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_FILT,
        S_FILT_DRAIN,
        S_MAIN,
        S_MAIN_DRAIN,
        S_WIN,
        S_MAC,
        S_ACC,
        S_SHIFT,
        S_FETCH,
        S_FETCH_DRAIN,
        S_FINAL,
        S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   issue_cnt, issue_nxt;
    logic [FW-1:0]   filt_idx, filt_nxt;
    logic [RW-1:0]   row_cnt, row_nxt;
    logic [1:0]      skip_cnt, skip_nxt;
    logic [N-1:0]    wf_en_nxt;

    always_comb begin
        state_nxt = state;
        issue_nxt = issue_cnt;
        filt_nxt  = filt_idx;
        row_nxt   = row_cnt;
        skip_nxt  = skip_cnt;

        // The filter slot advances on the strobe that writes its last word.
        if (write_filter_buff_counter_en && write_filter_buff_counter_cout)
            filt_nxt = filt_idx + FW'(1);

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_INIT;
                    filt_nxt  = '0;
                    row_nxt   = '0;
                end
            end
            S_INIT: begin
                state_nxt = S_FILT;
                issue_nxt = '0;
            end
            S_FILT: begin
                if (issue_cnt == IW'(FILT_ISSUES - 1))
                    state_nxt = S_FILT_DRAIN;
                else
                    issue_nxt = issue_cnt + IW'(1);
            end
            S_FILT_DRAIN: begin
                state_nxt = S_MAIN;
                issue_nxt = '0;
            end
            S_MAIN: begin
                if (issue_cnt == IW'(3))
                    state_nxt = S_MAIN_DRAIN;
                else
                    issue_nxt = issue_cnt + IW'(1);
            end
            S_MAIN_DRAIN: begin
                if (write_main_buff_counter_cout)
                    state_nxt = S_WIN;
            end
            S_WIN: begin
                state_nxt = S_MAC;
            end
            S_MAC: begin
                if (read_filter_buff_counter_cout)
                    state_nxt = S_ACC;
            end
            S_ACC: begin
                if (!read_main_buff_counter_cout) begin
                    state_nxt = S_WIN;
                end else if (row_cnt == RW'(ROWS - 1)) begin
                    state_nxt = S_FINAL;
                end else begin
                    state_nxt = S_SHIFT;
                    row_nxt   = row_cnt + RW'(1);
                    skip_nxt  = '0;
                end
            end
            S_SHIFT: begin
                if (skip_cnt == 2'd2)
                    state_nxt = S_FETCH;
                else
                    skip_nxt = skip_cnt + 2'd1;
            end
            S_FETCH: begin
                state_nxt = S_FETCH_DRAIN;
            end
            S_FETCH_DRAIN: begin
                if (write_main_buff_counter_cout)
                    state_nxt = S_WIN;
            end
            S_FINAL: begin
                state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Filter 0 goes to the MSB PE slot; the write lands one cycle after
        // the read was issued, so it uses the slot index as of that cycle.
        wf_en_nxt = '0;
        if (load_y) begin
            for (int i = 0; i < N; i++)
                wf_en_nxt[i] = (int'(filt_nxt) == N - 1 - i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                        <= S_IDLE;
            issue_cnt                    <= '0;
            filt_idx                     <= '0;
            row_cnt                      <= '0;
            skip_cnt                     <= '0;
            sel_x                        <= 1'b0;
            sel_y                        <= 1'b0;
            sel_z                        <= 1'b0;
            load_x                       <= 1'b0;
            load_y                       <= 1'b0;
            load_z                       <= 1'b0;
            mem_addr_sel                 <= 1'b0;
            write_filter_buff_en         <= '0;
            write_filter_buff_counter_en <= 1'b0;
            write_main_buff_en           <= 1'b0;
            write_main_buff_counter_en   <= 1'b0;
            shift_main_buff_en           <= 1'b0;
            read_main_buff_counter_en    <= 1'b0;
            read_filter_buff_counter_en  <= 1'b0;
            write_window_buff_en         <= 1'b0;
            partial_res_en               <= 1'b0;
            reset_mac                    <= 1'b0;
            shift_reg_en                 <= 1'b0;
            finalize_shift_reg           <= 1'b0;
            done                         <= 1'b0;
        end else begin
            state     <= state_nxt;
            issue_cnt <= issue_nxt;
            filt_idx  <= filt_nxt;
            row_cnt   <= row_nxt;
            skip_cnt  <= skip_nxt;

            sel_x <= (state_nxt == S_INIT);
            sel_y <= (state_nxt == S_INIT);
            sel_z <= (state_nxt == S_INIT);

            load_y       <= (state_nxt == S_FILT);
            mem_addr_sel <= (state_nxt == S_FILT);
            load_x       <= (state_nxt == S_MAIN) || (state_nxt == S_FETCH);
            load_z       <= (state_nxt == S_ACC);

            // Memory returns data one cycle after the issue, so write strobes
            // are the issue strobes delayed by one register stage.
            write_filter_buff_en         <= wf_en_nxt;
            write_filter_buff_counter_en <= load_y;
            write_main_buff_en           <= load_x;
            write_main_buff_counter_en   <= load_x || (state_nxt == S_SHIFT);
            shift_main_buff_en           <= (state == S_ACC) && (state_nxt == S_SHIFT);

            write_window_buff_en        <= (state_nxt == S_WIN);
            reset_mac                   <= (state_nxt == S_WIN);
            read_filter_buff_counter_en <= (state_nxt == S_MAC);
            partial_res_en              <= (state_nxt == S_MAC);
            shift_reg_en                <= (state_nxt == S_ACC);
            read_main_buff_counter_en   <= (state_nxt == S_ACC);
            finalize_shift_reg          <= (state_nxt == S_FINAL);
            done                        <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
`timescale 1ns/1ps
module tb_conv_sequencer;

    localparam int N    = 2;
    localparam int ROWS = 2;

    // Hand-computed for N=2, ROWS=2 (cycle 1 = INIT):
    // INIT 1, FILT 2-9, drain 10, MAIN 11-14, drain 15, row 0 windows 16-249,
    // SHIFT 250-252, FETCH 253, drain 254, row 1 windows 255-488,
    // FINAL 489, DONE 490. 13 windows per row -> 26 load_z, z = 0x40+26.
    localparam int EXP_DONE     = 490;
    localparam int EXP_SHIFT_AT = 250;
    localparam int EXP_LOADZ    = 26;
    localparam int EXP_Z        = 'h5A;

    typedef struct {
        int base;
        int done_at;
        int shift_at;
        int loadz;
        int z;
    } job_t;

    logic         clk;
    logic         rst;
    logic         start;
    logic         write_filter_buff_counter_cout;
    logic         write_main_buff_counter_cout;
    logic         read_filter_buff_counter_cout;
    logic         read_main_buff_counter_cout;
    logic         sel_x, sel_y, sel_z;
    logic         load_x, load_y, load_z;
    logic         mem_addr_sel;
    logic [N-1:0] write_filter_buff_en;
    logic         write_filter_buff_counter_en;
    logic         write_main_buff_en;
    logic         write_main_buff_counter_en;
    logic         shift_main_buff_en;
    logic         read_main_buff_counter_en;
    logic         read_filter_buff_counter_en;
    logic         write_window_buff_en;
    logic         partial_res_en;
    logic         reset_mac;
    logic         shift_reg_en;
    logic         finalize_shift_reg;
    logic         done;

    conv_sequencer #(.N(N), .ROWS(ROWS)) u_dut (
        .clk                            (clk),
        .rst                            (rst),
        .start                          (start),
        .write_filter_buff_counter_cout (write_filter_buff_counter_cout),
        .write_main_buff_counter_cout   (write_main_buff_counter_cout),
        .read_filter_buff_counter_cout  (read_filter_buff_counter_cout),
        .read_main_buff_counter_cout    (read_main_buff_counter_cout),
        .sel_x                          (sel_x),
        .sel_y                          (sel_y),
        .sel_z                          (sel_z),
        .load_x                         (load_x),
        .load_y                         (load_y),
        .load_z                         (load_z),
        .mem_addr_sel                   (mem_addr_sel),
        .write_filter_buff_en           (write_filter_buff_en),
        .write_filter_buff_counter_en   (write_filter_buff_counter_en),
        .write_main_buff_en             (write_main_buff_en),
        .write_main_buff_counter_en     (write_main_buff_counter_en),
        .shift_main_buff_en             (shift_main_buff_en),
        .read_main_buff_counter_en      (read_main_buff_counter_en),
        .read_filter_buff_counter_en    (read_filter_buff_counter_en),
        .write_window_buff_en           (write_window_buff_en),
        .partial_res_en                 (partial_res_en),
        .reset_mac                      (reset_mac),
        .shift_reg_en                   (shift_reg_en),
        .finalize_shift_reg             (finalize_shift_reg),
        .done                           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath counter and z PC models that feed the couts back.
    logic [1:0] wf_cnt, wm_cnt;
    logic [3:0] rf_cnt, rm_cnt;
    logic [7:0] z_pc;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wf_cnt <= '0;
            wm_cnt <= '0;
            rf_cnt <= '0;
            rm_cnt <= '0;
            z_pc   <= '0;
        end else begin
            if (write_filter_buff_counter_en) wf_cnt <= wf_cnt + 2'd1;
            if (write_main_buff_counter_en)   wm_cnt <= wm_cnt + 2'd1;
            if (read_filter_buff_counter_en)  rf_cnt <= rf_cnt + 4'd1;
            if (read_main_buff_counter_en)    rm_cnt <= (rm_cnt == 4'd12) ? 4'd0 : rm_cnt + 4'd1;
            if (sel_z)       z_pc <= 8'h40;
            else if (load_z) z_pc <= z_pc + 8'd1;
        end
    end

    assign write_filter_buff_counter_cout = (wf_cnt == 2'd3);
    assign write_main_buff_counter_cout   = (wm_cnt == 2'd3);
    assign read_filter_buff_counter_cout  = (rf_cnt == 4'd15);
    assign read_main_buff_counter_cout    = (rm_cnt == 4'd12);

    logic [31:0] outs;
    assign outs = 32'({sel_x, sel_y, sel_z, load_x, load_y, load_z, mem_addr_sel,
                       write_filter_buff_en, write_filter_buff_counter_en,
                       write_main_buff_en, write_main_buff_counter_en,
                       shift_main_buff_en, read_main_buff_counter_en,
                       read_filter_buff_counter_en, write_window_buff_en,
                       partial_res_en, reset_mac, shift_reg_en,
                       finalize_shift_reg, done});

    int   n_checks = 0;
    int   n_errors = 0;
    job_t exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard
    int n_loadz = 0;
    int n_shift = 0;
    int shift_at = -1;
    int prr_run = 0;
    int rm_prev = 0;
    int rm_ok = 0;

    initial begin
        int   k;
        int   exp_wf;
        int   exp_ly;
        job_t j;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("reset_outs_zero", int'(outs), 0);
                prr_run = 0;
                rm_prev = 0;
            end else if (exp_q.size() == 0) begin
                check("idle_outs_zero", int'(outs), 0);
                prr_run = 0;
                rm_prev = 0;
            end else begin
                k = cyc - exp_q[0].base;
                if (sel_x) begin
                    n_loadz  = 0;
                    n_shift  = 0;
                    shift_at = -1;
                end
                if (k >= 1 && k <= 12) begin
                    exp_ly = (k >= 2 && k <= 9) ? 1 : 0;
                    exp_wf = (k >= 3 && k <= 6) ? 2 : ((k >= 7 && k <= 10) ? 1 : 0);
                    check($sformatf("filt_sel_c%0d", k), int'({sel_x, sel_y, sel_z}), (k == 1) ? 7 : 0);
                    check($sformatf("filt_load_y_c%0d", k), int'(load_y), exp_ly);
                    check($sformatf("filt_addr_sel_c%0d", k), int'(mem_addr_sel), exp_ly);
                    check($sformatf("filt_wf_en_c%0d", k), int'(write_filter_buff_en), exp_wf);
                end
                check("addr_sel_load_x_excl", int'(mem_addr_sel && load_x), 0);
                check("wf_en_onehot0", int'($onehot0(write_filter_buff_en)), 1);
                if (load_z) n_loadz++;
                if (shift_main_buff_en) begin
                    n_shift++;
                    shift_at = k;
                end
                if (shift_reg_en) begin
                    check("mac_len", prr_run, 16);
                    check("reset_mac_before_mac", rm_ok, 1);
                end
                if (partial_res_en) begin
                    if (prr_run == 0) rm_ok = rm_prev;
                    prr_run++;
                end else begin
                    prr_run = 0;
                end
                rm_prev = int'(reset_mac);
                if (done) begin
                    j = exp_q.pop_front();
                    check("done_cycle", k, j.done_at);
                    check("load_z_count", n_loadz, j.loadz);
                    check("z_pc", int'(z_pc), j.z);
                    check("shift_count", n_shift, 1);
                    check("shift_cycle", shift_at, j.shift_at);
                end
            end
        end
    end

    // Stimulus
    int base;

    task automatic push_job(input int b);
        job_t r;
        r.base     = b;
        r.done_at  = EXP_DONE;
        r.shift_at = EXP_SHIFT_AT;
        r.loadz    = EXP_LOADZ;
        r.z        = EXP_Z;
        exp_q.push_back(r);
    endtask

    task automatic launch();
        base = cyc;
        push_job(base);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clk);
        check("job_timeout_pending", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        // Reset with start held high: must be ignored.
        rst   = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        repeat (4) @(negedge clk);

        // Full job with a stray start pulse mid-job.
        launch();
        while (cyc - base < 49) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(1200);

        // Reset in the middle of a MAC.
        launch();
        while (cyc - base < 100) begin
            @(posedge clk);
            #1;
        end
        check("pre_reset_in_mac", int'(partial_res_en), 1);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset_outs", int'(outs), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Fresh job after the abort.
        launch();
        wait_idle(1200);

        // start held high: second job follows one IDLE cycle after DONE.
        base = cyc;
        push_job(base);
        push_job(base + EXP_DONE + 1);
        start = 1'b1;
        while (cyc - base < EXP_DONE + 5) @(negedge clk);
        start = 1'b0;
        wait_idle(1200);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
